// File: rtl/axi_stream_record_decoder_if.sv
// Tagged AXI-Stream input and decoded-record output of the snoop-stream decoder.
// The master modport drives the stream and consumes records; the slave modport is the decoder.
interface axi_stream_record_decoder_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 64,
  parameter int BURST_LEN  = 8
);
  logic [DATA_WIDTH-1:0]   stream_tdata;
  logic                    stream_tlast;
  logic                    stream_tvalid;
  logic                    stream_tready;

  logic [2:0]              rec_type;
  logic [ADDR_WIDTH-1:0]   rec_addr;
  logic [1:0]              rec_resp;
  logic [DATA_WIDTH-1:0]   rec_data;
  logic [DATA_WIDTH/8-1:0] rec_strb;
  logic [BURST_LEN-1:0]    rec_beat;
  logic                    rec_last;
  logic                    rec_valid;
  logic                    rec_ready;

  modport master (
    output stream_tdata, stream_tlast, stream_tvalid,
    input  stream_tready,
    input  rec_type, rec_addr, rec_resp, rec_data, rec_strb, rec_beat, rec_last, rec_valid,
    output rec_ready
  );

  modport slave (
    input  stream_tdata, stream_tlast, stream_tvalid,
    output stream_tready,
    output rec_type, rec_addr, rec_resp, rec_data, rec_strb, rec_beat, rec_last, rec_valid,
    input  rec_ready
  );
endinterface

// File: rtl/axi_stream_record_decoder.sv
// Decodes tagged AR/R/AW/W/B snoop-stream records; per-type stats built only with AXI_STREAM_DECODER_STATS_EN.
// One register stage: record appears 1 cycle after its beat; stream stalls while a record waits on rec_ready.
module axi_stream_record_decoder #(
  parameter int DATA_WIDTH        = 128,
  parameter int ADDR_WIDTH        = 64,
  parameter int BURST_LEN         = 8,
  parameter int STREAM_TYPE_WIDTH = 3,
  parameter int ERR_CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  axi_stream_record_decoder_if.slave bus,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [31:0]              stat_ar,
  output logic [31:0]              stat_aw,
  output logic [31:0]              stat_b,
  output logic [31:0]              stat_r,
  output logic [31:0]              stat_w
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [STREAM_TYPE_WIDTH-1:0] TAG_AR = 0;
  localparam logic [STREAM_TYPE_WIDTH-1:0] TAG_R  = 1;
  localparam logic [STREAM_TYPE_WIDTH-1:0] TAG_AW = 2;
  localparam logic [STREAM_TYPE_WIDTH-1:0] TAG_W  = 3;
  localparam logic [STREAM_TYPE_WIDTH-1:0] TAG_B  = 4;

  typedef enum logic [1:0] {S_HDR, S_WDATA, S_RDATA, S_DROP} state_t;

  state_t                   r_state, w_state_nxt;
  logic [STRB_W-1:0]        r_strb;
  logic [BURST_LEN-1:0]     r_beat;
  logic                     r_rec_valid, r_rec_last;
  logic [2:0]               r_rec_type;
  logic [ADDR_WIDTH-1:0]    r_rec_addr;
  logic [1:0]               r_rec_resp;
  logic [DATA_WIDTH-1:0]    r_rec_data;
  logic [STRB_W-1:0]        r_rec_strb;
  logic [BURST_LEN-1:0]     r_rec_beat;
  logic                     r_err_pulse;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;

  logic                         w_tready, w_acc, w_emit, w_err, w_hdr_w, w_hdr_r, w_data_beat;
  logic [STREAM_TYPE_WIDTH-1:0] w_tag;
  logic [2:0]                   w_type;
  logic [ADDR_WIDTH-1:0]        w_addr;
  logic [1:0]                   w_resp;
  logic [DATA_WIDTH-1:0]        w_data;
  logic [STRB_W-1:0]            w_strb;
  logic [BURST_LEN-1:0]         w_beat;
  logic                         w_last;

  assign w_tready = ~r_rec_valid | bus.rec_ready;
  assign w_acc    = bus.stream_tvalid & w_tready;
  assign w_tag    = bus.stream_tdata[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_err       = 1'b0;
    w_hdr_w     = 1'b0;
    w_hdr_r     = 1'b0;
    w_data_beat = 1'b0;
    w_type      = 3'(w_tag);
    w_addr      = '0;
    w_resp      = '0;
    w_data      = '0;
    w_strb      = '0;
    w_beat      = '0;
    w_last      = 1'b0;
    if (w_acc) begin
      case (r_state)
        S_HDR: begin
          case (w_tag)
            TAG_AR, TAG_AW: begin
              if (bus.stream_tlast) begin
                w_emit = 1'b1;
                w_addr = bus.stream_tdata[ADDR_WIDTH-1:0];
                w_last = 1'b1;
              end else begin
                w_err       = 1'b1;
                w_state_nxt = S_DROP;
              end
            end
            TAG_B: begin
              if (bus.stream_tlast) begin
                w_emit = 1'b1;
                w_resp = bus.stream_tdata[1:0];
                w_last = 1'b1;
              end else begin
                w_err       = 1'b1;
                w_state_nxt = S_DROP;
              end
            end
            // A data-less R/W header is malformed but self-contained, so no drop is needed.
            TAG_W: begin
              if (bus.stream_tlast) w_err = 1'b1;
              else begin
                w_hdr_w     = 1'b1;
                w_state_nxt = S_WDATA;
              end
            end
            TAG_R: begin
              if (bus.stream_tlast) w_err = 1'b1;
              else begin
                w_hdr_r     = 1'b1;
                w_state_nxt = S_RDATA;
              end
            end
            default: begin
              w_err = 1'b1;
              if (!bus.stream_tlast) w_state_nxt = S_DROP;
            end
          endcase
        end
        S_WDATA, S_RDATA: begin
          w_emit      = 1'b1;
          w_data_beat = 1'b1;
          w_type      = (r_state == S_WDATA) ? 3'(TAG_W) : 3'(TAG_R);
          w_data      = bus.stream_tdata;
          w_strb      = r_strb;
          w_beat      = r_beat;
          w_last      = bus.stream_tlast;
          if (bus.stream_tlast) w_state_nxt = S_HDR;
        end
        default: begin
          if (bus.stream_tlast) w_state_nxt = S_HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_HDR;
    else         r_state <= w_state_nxt;
  end

  // Beat index wraps naturally at 2^BURST_LEN; long bursts are legal.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_strb <= '0;
      r_beat <= '0;
    end else if (w_hdr_w) begin
      r_strb <= bus.stream_tdata[STRB_W-1:0];
      r_beat <= '0;
    end else if (w_hdr_r) begin
      r_strb <= '1;
      r_beat <= '0;
    end else if (w_data_beat) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rec_valid <= 1'b0;
      r_rec_type  <= '0;
      r_rec_addr  <= '0;
      r_rec_resp  <= '0;
      r_rec_data  <= '0;
      r_rec_strb  <= '0;
      r_rec_beat  <= '0;
      r_rec_last  <= 1'b0;
    end else begin
      if (w_tready) r_rec_valid <= w_emit;
      if (w_emit) begin
        r_rec_type <= w_type;
        r_rec_addr <= w_addr;
        r_rec_resp <= w_resp;
        r_rec_data <= w_data;
        r_rec_strb <= w_strb;
        r_rec_beat <= w_beat;
        r_rec_last <= w_last;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err && !(&r_err_count)) r_err_count <= r_err_count + 1'b1;
    end
  end

`ifdef AXI_STREAM_DECODER_STATS_EN
  logic [31:0] r_stat_ar, r_stat_aw, r_stat_b, r_stat_r, r_stat_w;
  logic        w_done;
  assign w_done = r_rec_valid & bus.rec_ready & r_rec_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_ar <= '0;
      r_stat_aw <= '0;
      r_stat_b  <= '0;
      r_stat_r  <= '0;
      r_stat_w  <= '0;
    end else if (w_done) begin
      case (r_rec_type)
        3'(TAG_AR): r_stat_ar <= r_stat_ar + 32'd1;
        3'(TAG_AW): r_stat_aw <= r_stat_aw + 32'd1;
        3'(TAG_B):  r_stat_b  <= r_stat_b + 32'd1;
        3'(TAG_R):  r_stat_r  <= r_stat_r + 32'd1;
        3'(TAG_W):  r_stat_w  <= r_stat_w + 32'd1;
        default: ;
      endcase
    end
  end

  assign stat_ar = r_stat_ar;
  assign stat_aw = r_stat_aw;
  assign stat_b  = r_stat_b;
  assign stat_r  = r_stat_r;
  assign stat_w  = r_stat_w;
`else
  assign stat_ar = '0;
  assign stat_aw = '0;
  assign stat_b  = '0;
  assign stat_r  = '0;
  assign stat_w  = '0;
`endif

  assign bus.stream_tready = w_tready;
  assign bus.rec_valid     = r_rec_valid;
  assign bus.rec_type      = r_rec_type;
  assign bus.rec_addr      = r_rec_addr;
  assign bus.rec_resp      = r_rec_resp;
  assign bus.rec_data      = r_rec_data;
  assign bus.rec_strb      = r_rec_strb;
  assign bus.rec_beat      = r_rec_beat;
  assign bus.rec_last      = r_rec_last;
  assign err_pulse         = r_err_pulse;
  assign err_count         = r_err_count;
endmodule

// File: tb/tb_axi_stream_record_decoder.sv
// Scoreboard bench for axi_stream_record_decoder: expected records queued at drive time, matched on handshake.
module tb_axi_stream_record_decoder;
  localparam int DW = 128;
  localparam int AW = 64;
  localparam int BL = 8;
  localparam int EW = 4;

  typedef struct packed {
    logic [2:0]      t;
    logic [AW-1:0]   a;
    logic [1:0]      r;
    logic [DW-1:0]   d;
    logic [DW/8-1:0] s;
    logic [BL-1:0]   b;
    logic            l;
  } rec_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          err_pulse;
  logic [EW-1:0] err_count;
  logic [31:0]   stat_ar, stat_aw, stat_b, stat_r, stat_w;

  always #5 clk = ~clk;

  axi_stream_record_decoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) bus ();

  axi_stream_record_decoder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .STREAM_TYPE_WIDTH(3), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave),
    .err_pulse(err_pulse), .err_count(err_count),
    .stat_ar(stat_ar), .stat_aw(stat_aw), .stat_b(stat_b), .stat_r(stat_r), .stat_w(stat_w)
  );

  rec_t exp_q[$];
  rec_t got_q[$];
  int   got_cyc[$];
  int   cyc = 0;
  int   err_seen = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_stat[5];

  function automatic rec_t mk(input logic [2:0] t, input logic [AW-1:0] a, input logic [1:0] r,
                              input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                              input logic [BL-1:0] b, input logic l);
    rec_t x;
    x.t = t; x.a = a; x.r = r; x.d = d; x.s = s; x.b = b; x.l = l;
    return x;
  endfunction

  function automatic logic [DW-1:0] hdr(input logic [2:0] t, input logic [DW-4:0] p);
    return {t, p};
  endfunction

  function automatic logic [159:0] exp_stats();
`ifdef AXI_STREAM_DECODER_STATS_EN
    return {32'(exp_stat[0]), 32'(exp_stat[1]), 32'(exp_stat[2]), 32'(exp_stat[3]), 32'(exp_stat[4])};
`else
    return '0;
`endif
  endfunction

  always @(posedge clk) cyc++;

  // Records are sampled mid-cycle; a record with valid&ready here handshakes at the next rising edge.
  always @(negedge clk) begin
    if (resetn && bus.rec_valid && bus.rec_ready) begin
      got_q.push_back(mk(bus.rec_type, bus.rec_addr, bus.rec_resp, bus.rec_data,
                         bus.rec_strb, bus.rec_beat, bus.rec_last));
      got_cyc.push_back(cyc);
    end
    if (resetn && err_pulse) err_seen++;
  end

  task automatic push_exp(input rec_t r);
    exp_q.push_back(r);
    if (r.l && r.t <= 3'd4) exp_stat[r.t]++;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n;
    n = 0;
    bus.stream_tvalid = 1'b1;
    bus.stream_tdata  = d;
    bus.stream_tlast  = l;
    @(negedge clk);
    while (!bus.stream_tready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout tready stuck low, got=0 want=1");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.stream_tvalid = 1'b0;
    bus.stream_tlast  = 1'b0;
    bus.stream_tdata  = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.rec_ready = 1'b1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.rec_valid, bus.stream_tready, err_pulse, err_count} !== {1'b0, 1'b1, 1'b0, 4'h0}) begin
      n_bad++;
      $display("FAIL reset_ctl got v/rdy/ep/ec=%b%b%b%h want=0100", bus.rec_valid, bus.stream_tready, err_pulse, err_count);
    end
    n_cmp++;
    if (mk(bus.rec_type, bus.rec_addr, bus.rec_resp, bus.rec_data, bus.rec_strb, bus.rec_beat, bus.rec_last) !== '0) begin
      n_bad++;
      $display("FAIL reset_rec got=%h want=0", bus.rec_data);
    end
    n_cmp++;
    if ({stat_ar, stat_r, stat_aw, stat_w, stat_b} !== 160'd0) begin
      n_bad++;
      $display("FAIL reset_stats got=%h want=0", {stat_ar, stat_r, stat_aw, stat_w, stat_b});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ar();
    rec_t e, g;
    push_exp(mk(3'd0, 64'h1000, 2'd0, '0, '0, '0, 1'b1));
    send_beat(hdr(3'd0, 125'h1000), 1'b1);
    idle();
    n_cmp++;
    if (bus.rec_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ar_latency rec_valid got=%b want=1", bus.rec_valid);
    end
    repeat (5) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL ar_rec got=none want=%h", e); end
      else begin
        g = got_q.pop_front(); void'(got_cyc.pop_front());
        if (g !== e) begin n_bad++; $display("FAIL ar_rec got=%h want=%h", g, e); end
      end
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++; $display("FAIL ar_extra got=%0d extra records want=0", got_q.size());
      got_q.delete(); got_cyc.delete();
    end
  endtask

  task automatic test_w_burst();
    rec_t e, g;
    logic [DW-1:0] d;
    send_beat(hdr(3'd3, 125'h00FF), 1'b0);
    for (int i = 0; i < 3; i++) begin
      d = DW'(8'hA0 + i);
      push_exp(mk(3'd3, '0, 2'd0, d, 16'h00FF, BL'(i), i == 2));
      send_beat(d, i == 2);
    end
    idle();
    // A following AR proves the FSM returned to header parsing.
    push_exp(mk(3'd0, 64'h55, 2'd0, '0, '0, '0, 1'b1));
    send_beat(hdr(3'd0, 125'h55), 1'b1);
    idle();
    repeat (5) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL w_rec got=none want=%h", e); end
      else begin
        g = got_q.pop_front(); void'(got_cyc.pop_front());
        if (g !== e) begin n_bad++; $display("FAIL w_rec got=%h want=%h", g, e); end
      end
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++; $display("FAIL w_extra got=%0d extra records want=0", got_q.size());
      got_q.delete(); got_cyc.delete();
    end
  endtask

  task automatic test_r_backpressure();
    rec_t e, g;
    logic [DW-1:0] held;
    for (int i = 0; i < 4; i++)
      push_exp(mk(3'd1, '0, 2'd0, DW'(8'hB0 + i), '1, BL'(i), i == 3));
    fork
      begin
        send_beat(hdr(3'd1, 125'h0), 1'b0);
        for (int i = 0; i < 4; i++) send_beat(DW'(8'hB0 + i), i == 3);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.rec_ready = 1'b0;
        @(negedge clk);
        held = bus.rec_data;
        n_cmp++;
        if (bus.rec_valid !== 1'b1 || held !== DW'(8'hB1)) begin
          n_bad++; $display("FAIL r_hold_start got v=%b d=%h want v=1 d=b1", bus.rec_valid, held);
        end
        repeat (5) begin
          @(negedge clk);
          n_cmp++;
          if (bus.stream_tready !== 1'b0 || bus.rec_data !== held) begin
            n_bad++;
            $display("FAIL r_hold got rdy=%b d=%h want rdy=0 d=%h", bus.stream_tready, bus.rec_data, held);
          end
        end
        @(posedge clk);
        #1 bus.rec_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL r_rec got=none want=%h", e); end
      else begin
        g = got_q.pop_front(); void'(got_cyc.pop_front());
        if (g !== e) begin n_bad++; $display("FAIL r_rec got=%h want=%h", g, e); end
      end
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++; $display("FAIL r_extra got=%0d extra records want=0", got_q.size());
      got_q.delete(); got_cyc.delete();
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, g;
    int   c[2];
    int   k;
    push_exp(mk(3'd4, '0, 2'b10, '0, '0, '0, 1'b1));
    push_exp(mk(3'd2, 64'hFFFF_0000, 2'd0, '0, '0, '0, 1'b1));
    send_beat(hdr(3'd4, 125'h2), 1'b1);
    send_beat(hdr(3'd2, 125'hFFFF_0000), 1'b1);
    idle();
    repeat (5) @(posedge clk); #1;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL b2b_rec got=none want=%h", e); end
      else begin
        g = got_q.pop_front(); c[k] = got_cyc.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL b2b_rec got=%h want=%h", g, e); end
      end
      k++;
    end
    n_cmp++;
    if (c[1] - c[0] != 1) begin
      n_bad++; $display("FAIL b2b_spacing got=%0d cycles want=1", c[1] - c[0]);
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++; $display("FAIL b2b_extra got=%0d extra records want=0", got_q.size());
      got_q.delete(); got_cyc.delete();
    end
    n_cmp++;
    if ({stat_ar, stat_r, stat_aw, stat_w, stat_b} !== exp_stats()) begin
      n_bad++; $display("FAIL stats got=%h want=%h", {stat_ar, stat_r, stat_aw, stat_w, stat_b}, exp_stats());
    end
  endtask

  task automatic test_framing_error();
    rec_t e, g;
    int   e0;
    e0 = err_seen;
    send_beat(hdr(3'd6, 125'h0), 1'b0);
    idle();
    repeat (2) @(posedge clk); #1;
    send_beat(128'hDEAD, 1'b0);
    send_beat(128'hBEEF, 1'b1);
    idle();
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (err_seen - e0 != 1 || err_count !== 4'd1) begin
      n_bad++; $display("FAIL drop_err got pulses=%0d cnt=%0d want 1/1", err_seen - e0, err_count);
    end
    push_exp(mk(3'd0, 64'h3000, 2'd0, '0, '0, '0, 1'b1));
    send_beat(hdr(3'd0, 125'h3000), 1'b1);
    idle();
    repeat (5) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL err_ar_rec got=none want=%h", e); end
      else begin
        g = got_q.pop_front(); void'(got_cyc.pop_front());
        if (g !== e) begin n_bad++; $display("FAIL err_ar_rec got=%h want=%h", g, e); end
      end
    end
    send_beat(hdr(3'd1, 125'h0), 1'b1);
    idle();
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (err_seen - e0 != 2 || err_count !== 4'd2) begin
      n_bad++; $display("FAIL r_nodata_err got pulses=%0d cnt=%0d want 2/2", err_seen - e0, err_count);
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++; $display("FAIL err_extra got=%0d extra records want=0", got_q.size());
      got_q.delete(); got_cyc.delete();
    end
  endtask

  task automatic test_err_saturate();
    int e0;
    e0 = err_seen;
    for (int i = 0; i < 20; i++) send_beat(hdr((i % 2 == 0) ? 3'd1 : 3'd7, 125'h0), 1'b1);
    idle();
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (err_seen - e0 != 20 || err_count !== 4'hF) begin
      n_bad++; $display("FAIL err_sat got pulses=%0d cnt=%0d want 20/15", err_seen - e0, err_count);
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++; $display("FAIL sat_extra got=%0d extra records want=0", got_q.size());
      got_q.delete(); got_cyc.delete();
    end
  endtask

  task automatic test_beat_wrap();
    rec_t e, g;
    send_beat(hdr(3'd1, 125'h0), 1'b0);
    for (int i = 0; i < 258; i++) begin
      push_exp(mk(3'd1, '0, 2'd0, DW'(i), '1, BL'(i), i == 257));
      send_beat(DW'(i), i == 257);
    end
    idle();
    repeat (5) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL wrap_rec got=none want=%h", e); end
      else begin
        g = got_q.pop_front(); void'(got_cyc.pop_front());
        if (g !== e) begin n_bad++; $display("FAIL wrap_rec got=%h want=%h", g, e); end
      end
    end
    n_cmp++;
    if (got_q.size() != 0 || err_count !== 4'hF) begin
      n_bad++; $display("FAIL wrap_extra got recs=%0d cnt=%0d want 0/15", got_q.size(), err_count);
      got_q.delete(); got_cyc.delete();
    end
  endtask

  task automatic test_reset_midburst();
    rec_t e, g;
    push_exp(mk(3'd3, '0, 2'd0, 128'hC0, 16'h0F0F, '0, 1'b0));
    send_beat(hdr(3'd3, 125'h0F0F), 1'b0);
    send_beat(128'hC0, 1'b0);
    send_beat(128'hC1, 1'b0);
    idle();
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (bus.rec_valid !== 1'b0 || err_count !== 4'd0) begin
      n_bad++; $display("FAIL rst_mid got v=%b cnt=%0d want v=0 cnt=0", bus.rec_valid, err_count);
    end
    for (int i = 0; i < 5; i++) exp_stat[i] = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    push_exp(mk(3'd0, 64'h2000, 2'd0, '0, '0, '0, 1'b1));
    send_beat(hdr(3'd0, 125'h2000), 1'b1);
    idle();
    repeat (5) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL rst_rec got=none want=%h", e); end
      else begin
        g = got_q.pop_front(); void'(got_cyc.pop_front());
        if (g !== e) begin n_bad++; $display("FAIL rst_rec got=%h want=%h", g, e); end
      end
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++; $display("FAIL rst_extra got=%0d extra records want=0", got_q.size());
      got_q.delete(); got_cyc.delete();
    end
    n_cmp++;
    if ({stat_ar, stat_r, stat_aw, stat_w, stat_b} !== exp_stats()) begin
      n_bad++; $display("FAIL rst_stats got=%h want=%h", {stat_ar, stat_r, stat_aw, stat_w, stat_b}, exp_stats());
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) exp_stat[i] = 0;
    idle();
    bus.rec_ready = 1'b1;
    test_reset();
    test_ar();
    test_w_burst();
    test_r_backpressure();
    test_back_to_back();
    test_framing_error();
    test_err_saturate();
    test_beat_wrap();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
